// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised float add/subtract datapath:
// status bit positions, FSM state encoding and the exponent bias helper.
package fp_pkg;

  localparam int ST_ZERO    = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_t;

  // Exponent bias for an exp_w-bit biased exponent field.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_normalizer.sv
// Combinational normaliser: takes the raw significand sum (carry bit on top,
// guard/round/sticky at the bottom) and returns a significand whose leading
// one sits in the MSB, with the exponent adjusted to match.
module fp_normalizer #(
  parameter int MAN_W = 25,
  parameter int EXP_W = 6
) (
  input  logic [MAN_W+4:0]        sum,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic [MAN_W+3:0]        sig_out,
  output logic signed [EXP_W+1:0] exp_out,
  output logic                    is_zero
);

  localparam int SW   = MAN_W + 4;
  localparam int XW   = EXP_W + 2;
  localparam int LZ_W = $clog2(SW + 1);

  logic [LZ_W-1:0] lzc;

  // Leading-zero count below the carry bit, then a single shift either way.
  always_comb begin
    lzc = LZ_W'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lzc = LZ_W'(SW - 1 - i);
    end
    is_zero = (sum == '0);
    if (sum[SW]) begin
      // Carry out: drop one bit into sticky and bump the exponent.
      sig_out = {sum[SW:2], sum[1] | sum[0]};
      exp_out = exp_in + XW'(1);
    end else begin
      sig_out = sum[SW-1:0] << lzc;
      exp_out = exp_in - XW'(lzc);
    end
  end

endmodule

// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point adder/subtractor for the {sign, EXP_W, MAN_W}
// format with implicit leading one, no denormals, no Inf/NaN.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise results are truncated toward zero. INEXACT is reported either way.
module fp_addsub_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                   clock_100kHz,
  input  logic                   reset,
  input  logic                   start_in,
  input  logic                   op_sub_in,
  input  logic [EXP_W+MAN_W:0]   op_A_in,
  input  logic [EXP_W+MAN_W:0]   op_B_in,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int SW      = MAN_W + 4;   // implicit one + fraction + G/R/S
  localparam int XW      = EXP_W + 2;   // signed exponent with headroom
  localparam int EXP_MAX = 2 * fp_bias(EXP_W) + 1;

  state_t               state_reg;
  logic [W-1:0]         a_reg, b_reg;
  logic                 sub_reg;
  logic [SW-1:0]        big_sig_reg, small_sig_reg;
  logic signed [XW-1:0] exp_reg;
  logic                 sign_reg, eff_sub_reg;
  logic [SW:0]          sum_reg;
  logic [SW-1:0]        norm_sig_reg;
  logic signed [XW-1:0] norm_exp_reg;
  logic                 norm_zero_reg;
  logic [W-1:0]         res_reg;
  logic [3:0]           res_status_reg;
  logic                 commit_reg;

  // Alignment signals
  logic [EXP_W-1:0] ea, eb, e_big, e_small, e_diff;
  logic [W-2:0]     mag_a, mag_b;
  logic [SW-1:0]    sig_a, sig_b, sig_big, sig_small, sig_aligned;
  logic             a_big, sb_eff, lost;

  // Order operands by magnitude and shift the smaller one, folding lost bits into sticky.
  always_comb begin
    ea        = a_reg[W-2:MAN_W];
    eb        = b_reg[W-2:MAN_W];
    mag_a     = (ea == '0) ? '0 : a_reg[W-2:0];
    mag_b     = (eb == '0) ? '0 : b_reg[W-2:0];
    sig_a     = (ea == '0) ? '0 : {1'b1, a_reg[MAN_W-1:0], 3'b000};
    sig_b     = (eb == '0) ? '0 : {1'b1, b_reg[MAN_W-1:0], 3'b000};
    a_big     = (mag_a >= mag_b);
    sb_eff    = b_reg[W-1] ^ sub_reg;
    e_big     = a_big ? ea : eb;
    e_small   = a_big ? eb : ea;
    sig_big   = a_big ? sig_a : sig_b;
    sig_small = a_big ? sig_b : sig_a;
    e_diff    = e_big - e_small;
    lost      = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (i < int'(e_diff)) lost = lost | sig_small[i];
    end
    if (int'(e_diff) >= SW - 1)
      sig_aligned = {{(SW-1){1'b0}}, |sig_small};
    else
      sig_aligned = (sig_small >> e_diff) | {{(SW-1){1'b0}}, lost};
  end

  // Normaliser output
  logic [SW-1:0]        nz_sig;
  logic signed [XW-1:0] nz_exp;
  logic                 nz_zero;

  fp_normalizer #(
    .MAN_W (MAN_W),
    .EXP_W (EXP_W)
  ) u_norm (
    .sum     (sum_reg),
    .exp_in  (exp_reg),
    .sig_out (nz_sig),
    .exp_out (nz_exp),
    .is_zero (nz_zero)
  );

  // Rounding signals
  logic [MAN_W:0]       mant;
  logic                 g, r, s, inc, inexact;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_next;
  logic [3:0]           st_next;

  // Round, renormalise on rounding carry, then classify zero/overflow/underflow.
  always_comb begin
    mant    = norm_sig_reg[SW-1:3];
    g       = norm_sig_reg[2];
    r       = norm_sig_reg[1];
    s       = norm_sig_reg[0];
    inexact = g | r | s;
`ifdef FP_ROUND_NEAREST_EN
    inc     = g & (r | s | mant[0]);
`else
    inc     = 1'b0;
`endif
    rnd     = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    frac_r  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    exp_r   = norm_exp_reg + {{(XW-1){1'b0}}, rnd[MAN_W+1]};
    res_next = '0;
    st_next  = '0;
    if (norm_zero_reg) begin
      st_next[ST_ZERO] = 1'b1;
    end else if (int'(exp_r) > EXP_MAX) begin
      res_next            = {sign_reg, {(W-1){1'b1}}};
      st_next[ST_OVF]     = 1'b1;
      st_next[ST_INEXACT] = 1'b1;
    end else if (int'(exp_r) < 1) begin
      st_next[ST_UNF]     = 1'b1;
      st_next[ST_ZERO]    = 1'b1;
      st_next[ST_INEXACT] = 1'b1;
    end else begin
      res_next            = {sign_reg, exp_r[EXP_W-1:0], frac_r};
      st_next[ST_INEXACT] = inexact;
    end
  end

  // Sequencer and datapath registers. The FSM returns to IDLE one edge before
  // the result is committed, so busy_out gates acceptance during that cycle.
  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      sub_reg        <= 1'b0;
      big_sig_reg    <= '0;
      small_sig_reg  <= '0;
      exp_reg        <= '0;
      sign_reg       <= 1'b0;
      eff_sub_reg    <= 1'b0;
      sum_reg        <= '0;
      norm_sig_reg   <= '0;
      norm_exp_reg   <= '0;
      norm_zero_reg  <= 1'b0;
      res_reg        <= '0;
      res_status_reg <= '0;
      commit_reg     <= 1'b0;
      data_out       <= '0;
      status_out     <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (commit_reg) begin
        data_out   <= res_reg;
        status_out <= res_status_reg;
        done_out   <= 1'b1;
        busy_out   <= 1'b0;
        commit_reg <= 1'b0;
      end
      case (state_reg)
        S_IDLE: begin
          if (start_in && !busy_out) begin
            a_reg     <= op_A_in;
            b_reg     <= op_B_in;
            sub_reg   <= op_sub_in;
            busy_out  <= 1'b1;
            state_reg <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_sig_reg   <= sig_big;
          small_sig_reg <= sig_aligned;
          exp_reg       <= {2'b00, e_big};
          sign_reg      <= a_big ? a_reg[W-1] : sb_eff;
          eff_sub_reg   <= a_reg[W-1] ^ sb_eff;
          state_reg     <= S_ADD;
        end
        S_ADD: begin
          sum_reg   <= eff_sub_reg ? ({1'b0, big_sig_reg} - {1'b0, small_sig_reg})
                                   : ({1'b0, big_sig_reg} + {1'b0, small_sig_reg});
          state_reg <= S_NORM;
        end
        S_NORM: begin
          norm_sig_reg  <= nz_sig;
          norm_exp_reg  <= nz_exp;
          norm_zero_reg <= nz_zero;
          state_reg     <= S_ROUND;
        end
        S_ROUND: begin
          res_reg        <= res_next;
          res_status_reg <= st_next;
          commit_reg     <= 1'b1;
          state_reg      <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param at default widths (W=32).
module tb_fp_addsub_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic        op_sub_in;
  logic [31:0] op_A_in, op_B_in;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        busy_out, done_out;

  always #5 clk = ~clk;

  fp_addsub_param dut (
    .clock_100kHz (clk),
    .reset        (reset),
    .start_in     (start_in),
    .op_sub_in    (op_sub_in),
    .op_A_in      (op_A_in),
    .op_B_in      (op_B_in),
    .data_out     (data_out),
    .status_out   (status_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] TIE_RES   = 32'h3E000002;
  localparam logic [31:0] UP_RES    = 32'h3E000001;
  localparam logic [31:0] CARRY_RES = 32'h40000000;
`else
  localparam logic [31:0] TIE_RES   = 32'h3E000001;
  localparam logic [31:0] UP_RES    = 32'h3E000000;
  localparam logic [31:0] CARRY_RES = 32'h3FFFFFFF;
`endif

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Output monitor: every done pulse pops one expected transaction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("data", data_out, e.d);
        chk("status", {28'd0, status_out}, {28'd0, e.s});
        chk("latency", 32'(cyc - e.cyc), 32'd5);
        $display("txn data=%h status=%b want=%h/%b latency=%0d",
                 data_out, status_out, e.d, e.s, cyc - e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] d, input logic [3:0] s);
    wait_idle();
    op_A_in   = a;
    op_B_in   = b;
    op_sub_in = sub;
    start_in  = 1'b1;
    sb_q.push_back('{d, s, cyc + 1});
    @(negedge clk);
    start_in = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start_in  = 1'b0;
    op_sub_in = 1'b0;
    op_A_in   = '0;
    op_B_in   = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 32'h0);
    chk("rst_status", {28'd0, status_out}, 32'h0);
    chk("rst_busy", {31'd0, busy_out}, 32'h0);
    chk("rst_done", {31'd0, done_out}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op(32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0000); // 1+2=3
    run_op(32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 4'b0001); // exact cancel
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 4'b1010); // overflow
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 4'b1010); // negative overflow
    run_op(32'h3E000001, 32'h0A000000, 1'b0, TIE_RES,      4'b1000); // tie
    run_op(32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000); // tie, even lsb
    run_op(32'h3E000000, 32'h0B000000, 1'b0, UP_RES,       4'b1000); // above half
    run_op(32'h3FFFFFFF, 32'h0B000000, 1'b0, CARRY_RES,    4'b1000); // rounding carry
    run_op(32'h02000000, 32'h02000001, 1'b1, 32'h00000000, 4'b1101); // underflow
    run_op(32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0000); // 1-2=-1
    run_op(32'h41000000, 32'h3E000000, 1'b0, 32'h42000000, 4'b0000); // 3+1=4
    run_op(32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b0000); // -1+-1
    run_op(32'h00123456, 32'h40000000, 1'b0, 32'h40000000, 4'b0000); // exp0 is zero
    run_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0001); // 0-0
    run_op(32'h40000000, 32'h02000000, 1'b0, 32'h40000000, 4'b1000); // sticky only
    drain();

    // Start pulses while busy are ignored
    run_op(32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0000);
    op_A_in  = 32'h7FFFFFFF;
    op_B_in  = 32'h7FFFFFFF;
    start_in = 1'b1;
    repeat (3) @(negedge clk);
    start_in = 1'b0;
    drain();

    // Start held high: one accept every 6 cycles
    wait_idle();
    op_A_in   = 32'h41000000;
    op_B_in   = 32'h3E000000;
    op_sub_in = 1'b0;
    start_in  = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back('{32'h42000000, 4'b0000, cyc + 1 + 6 * k});
    repeat (19) @(negedge clk);
    start_in = 1'b0;
    drain();

    // Reset during NORM aborts the operation
    wait_idle();
    op_A_in   = 32'h3E000000;
    op_B_in   = 32'h40000000;
    op_sub_in = 1'b0;
    start_in  = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_data", data_out, 32'h0);
    chk("abort_status", {28'd0, status_out}, 32'h0);
    chk("abort_busy", {31'd0, busy_out}, 32'h0);
    chk("abort_done", {31'd0, done_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    run_op(32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_addsub_param.md
# fp_addsub_param

- Parametrised, multi-cycle floating-point adder/subtractor for the team's custom float format: sign, EXP_W-bit biased exponent, MAN_W-bit fraction with an implicit leading one.
- Next generation of the fixed 32-bit PontosFlutuantes datapath. Generalised widths, an add/subtract mode select, a start/done handshake and selectable rounding.
- Sits behind the operand registers and drives the result and status registers.

## Interface
- EXP_W, 6, exponent width; bias = 2^(EXP_W-1)-1 (31 by default)
- MAN_W, 25, stored fraction width; total word W = 1+EXP_W+MAN_W (32 by default)
- clock_100kHz  in  1  single system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- start_in  in  1  request; sampled only in IDLE
- op_sub_in  in  1  0 = A+B, 1 = A-B; captured with operands
- op_A_in  in  W  operand A {sign, exp, frac}
- op_B_in  in  W  operand B
- data_out  out  W  result; held until the next completion
- status_out  out  4  [0] ZERO, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT; held with data_out
- busy_out  out  1  operation in progress
- done_out  out  1  one-cycle pulse; data_out/status_out valid from this edge

## Operation
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE; no other transitions; no stalls.
- IDLE: start_in=1 captures op_A_in, op_B_in and op_sub_in and sets busy_out. start_in in any other state is ignored.
- Exponent field 0 means zero, regardless of fraction. No denormals. Inputs with exp=0 are treated as exact zero.
- No infinities or NaN. All-ones exponent is an ordinary normal exponent.
- Effective subtraction = sA ^ sB ^ op_sub. The larger magnitude is swapped into the first slot. Result sign = sign of the larger operand (B's sign inverted when op_sub).
- ALIGN: shift the smaller significand right by the exponent difference in one barrel shift. Keep guard, round and sticky bits (MAN_W+4 bit datapath). Difference >= MAN_W+3 leaves only sticky.
- ADD: add or subtract significands, with one carry bit.
- NORM: on carry-out, shift right 1 and increment exponent. Otherwise count leading zeros and shift left, decrementing exponent.
- ROUND: INEXACT = G|R|S. Rounding mode is set by the macro in Configuration. A rounding carry renormalises in the same cycle.
- Exact cancellation: result +0, ZERO=1.
- Overflow (exponent > all-ones): saturate to max finite magnitude with the correct sign. Sets OVERFLOW|INEXACT.
- Underflow (exponent < 1): flush to +0. Sets UNDERFLOW|ZERO|INEXACT.
- ZERO is set iff data_out == 0.

## Timing
- Reset (asynchronous, immediate): state=IDLE; data_out=0, status_out=0, busy_out=0, done_out=0; captured operands cleared.
- Reset mid-operation aborts the operation; no done_out is produced.
- Start accepted at edge E0: busy_out=1 after E0.
- At E5: data_out, status_out updated; done_out=1; busy_out=0; state=IDLE.
- At E6: done_out=0. A start_in high at E6 is accepted.
- Fixed latency 5 cycles; maximum throughput one operation per 6 cycles.
- start_in held high continuously: a new operation is accepted at every IDLE edge.

## Configuration
- FP_ROUND_NEAREST_EN defined: round to nearest, ties to even. Increment when G & (R|S|lsb).
- FP_ROUND_NEAREST_EN undefined: truncate (toward zero); G/R/S are discarded.
- INEXACT and the flag semantics are identical in both builds.

## Structure
- Package fp_pkg holds:
  - status bit index constants (ST_ZERO=0, ST_OVF=1, ST_UNF=2, ST_INEXACT=3)
  - the FSM state enum
  - a bias function of EXP_W
- Sub-module fp_normalizer: combinational leading-zero count plus left/right shift and exponent adjust. Parametrised by MAN_W/EXP_W and instantiated once in NORM.

## Test plan
- Default widths, A=0x3E000000 (1.0), B=0x40000000 (2.0), op_sub=0 -> at E5 data_out=0x41000000 (3.0), status=0000, done_out one cycle.
- A=B=0x40000000, op_sub=1 -> data_out=0x00000000, status=0001.
- A=B=0x7FFFFFFF, op_sub=0 -> data_out=0x7FFFFFFF, status=1010.
- A=0x3E000001, B=0x0A000000 (2^-26, exact tie) -> 0x3E000002 with FP_ROUND_NEAREST_EN, 0x3E000001 without; status=1000 in both builds.
- A=0x02000000, B=0x02000001, op_sub=1 -> data_out=0x00000000, status=1101.
- Start, then assert reset during NORM -> all outputs 0 immediately, no done_out. A start after release completes normally. Start pulses while busy are ignored.
